scan_mux: RTL and testbench
===========================

Name: scan_mux

Overview:
Parametrised, registered N-channel multiplexer with two modes. In manual mode it selects one channel per cycle from an input select. In scan mode it sweeps all channels in order, holding each for a programmable dwell time. This makes it a time-division front end for serial readout and test observation.
Every output is registered and is reported together with the channel it came from. This keeps downstream logic cycle-aligned.

Parameters:
N_CH, 16, number of input channels (2..256)
W, 1, bits per channel
SEL_W, 4, select/channel-index width; must equal clog2(N_CH)
DWELL_W, 8, width of dwell-count input

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  block enable; 0 forces IDLE
mode  input  1  0 = manual select, 1 = auto scan
sel  input  SEL_W  manual channel select
dwell  input  DWELL_W  scan hold; each channel is presented dwell+1 cycles
in  input  N_CH*W  packed channels; channel k = in[k*W +: W]
out  output  W  registered selected channel data
out_ch  output  SEL_W  channel index of current out
out_valid  output  1  out/out_ch are valid this cycle
wrap  output  1  one-cycle pulse marking the last sample of a full sweep

Behaviour:
- Reset (async, rst_n=0): out=0, out_ch=0, out_valid=0, wrap=0; internal cur_ch=0, cnt=0, dwell_lat=0; state=IDLE. Release is synchronous to the next clk edge.
- States: IDLE, MANUAL, SCAN. Evaluated every edge, in this priority:
  - en=0 -> IDLE
  - en=1 & mode=0 -> MANUAL
  - en=1 & mode=1 -> SCAN
- IDLE:
  - out_valid=0 and wrap=0 from the next edge.
  - out and out_ch hold their last value.
  - cur_ch=0, cnt=0.
- MANUAL (1-cycle latency): at edge t, out <= in[sel(t)], out_ch <= sel(t), out_valid <= 1, wrap <= 0.
  - If sel >= N_CH (non-power-of-2 N_CH): out <= 0, out_ch <= sel, out_valid <= 0.
- SCAN entry: on the first SCAN cycle (from IDLE or MANUAL):
  - cur_ch=0, cnt=0, dwell_lat <= dwell.
  - That edge registers in[0].
- SCAN, each edge:
  - out <= in[cur_ch], out_ch <= cur_ch, out_valid <= 1.
  - If cnt == dwell_lat: cnt <= 0 and cur_ch advances. The new dwell value is latched into dwell_lat at this boundary only; changes mid-channel are ignored.
  - Otherwise cnt <= cnt + 1.
  - Advance rule: cur_ch <= cur_ch + 1, except when cur_ch == N_CH-1, where cur_ch <= 0 (wrap at N_CH, not 2^SEL_W).
- wrap <= 1 on the edge that registers the final dwell sample of channel N_CH-1; otherwise 0.
  - Exactly one wrap pulse per N_CH*(dwell+1) cycles.
- Data is sampled live: out reflects `in` at the sampling edge, not at the channel boundary. A change in `in` during a dwell is visible on the next cycle.
- Mode change mid-sweep:
  - SCAN->MANUAL: the next edge is a manual sample.
  - MANUAL->SCAN: the sweep restarts at channel 0.
- en deasserted mid-sweep: position is discarded; re-enable restarts at channel 0.
- Async reset mid-operation: all outputs clear immediately, without waiting for a clock edge.
- Width rule: cnt is DWELL_W bits and never overflows, since cnt <= dwell_lat. dwell=0 gives one cycle per channel.

Test Plan:
1. N_CH=16, W=1, in=16'h33ff, mode=0. Apply sel=3, a, 6, c on successive edges.
   -> One cycle later each: out=1, 0, 1, 1; out_ch=3, a, 6, c; out_valid=1; wrap=0.
2. Same in, mode=1, dwell=0.
   -> 16 consecutive outs (ch0..15) = 1,1,1,1,1,1,1,1,1,1,0,0,1,1,0,0.
   -> wrap=1 only with out_ch=15; out_ch returns to 0 on the next cycle.
3. dwell=2 scan.
   -> Each channel is held 3 cycles; wrap pulses every 48 cycles.
   -> Change dwell to 0 midway through ch5: ch5 still gets 3 cycles; ch6 onward gets 1 cycle each.
4. N_CH=12, SEL_W=4, W=8, channel k = 8'h10+k.
   -> Scan: out runs 8'h10..8'h1b, then wraps to 8'h10; wrap pulses with out_ch=11.
   -> Manual sel=4'hd: out_valid=0, out=0.
5. Drop rst_n mid-scan at ch7.
   -> out, out_ch, out_valid and wrap go to 0 before the next clk edge.
   -> After release with en=1, mode=1: the sweep restarts at ch0.
6. Toggle en 1->0->1 during a scan at ch9.
   -> out_valid=0 while disabled and out holds its last value.
   -> On re-enable, the first valid out_ch=0.

Source files
------------

// File: rtl/scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : scan_mux
// Description : Registered N-channel multiplexer with manual and scan modes.
//               Manual mode registers the channel picked by sel. Scan mode
//               sweeps channels 0..N_CH-1 and holds each for dwell+1 cycles.
//               Every registered sample comes with the index of its channel.
// Ports       : clk       rising-edge clock
//               rst_n     asynchronous active-low reset
//               en        block enable (0 -> idle)
//               mode      0 = manual select, 1 = auto scan
//               sel       manual channel select
//               dwell     scan hold; each channel is shown dwell+1 cycles
//               in        packed channels, channel k = in[k*W +: W]
//               out       registered channel data
//               out_ch    channel index of out
//               out_valid out/out_ch valid
//               wrap      pulse on the last sample of a full sweep
// Revision    : 1.0 - initial release
// ============================================================================
module scan_mux #(
    parameter int N_CH    = 16,
    parameter int W       = 1,
    parameter int SEL_W   = 4,
    parameter int DWELL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic [DWELL_W-1:0]   dwell,
    input  logic [N_CH*W-1:0]    in,
    output logic [W-1:0]         out,
    output logic [SEL_W-1:0]     out_ch,
    output logic                 out_valid,
    output logic                 wrap
);

    localparam int                 c_n_slot   = 2**SEL_W;
    localparam logic [SEL_W-1:0]   c_last_ch  = SEL_W'(N_CH - 1);
    localparam logic [SEL_W-1:0]   c_ch_one   = SEL_W'(1);
    localparam logic [DWELL_W-1:0] c_cnt_one  = DWELL_W'(1);

    typedef enum logic [1:0] {
        c_st_idle   = 2'd0,
        c_st_manual = 2'd1,
        c_st_scan   = 2'd2
    } state_t;

    // Channel table padded to the full select range. Slots at or beyond N_CH
    // read as zero and are flagged out of range, so a manual select of a
    // non-existent channel yields out=0 / out_valid=0 without extra muxing.
    logic [W-1:0]        w_chan [c_n_slot];
    logic [c_n_slot-1:0] w_in_range;

    genvar k;
    generate
        for (k = 0; k < c_n_slot; k++) begin : g_chan
            if (k < N_CH) begin : g_real
                assign w_chan[k]     = in[k*W +: W];
                assign w_in_range[k] = 1'b1;
            end else begin : g_pad
                assign w_chan[k]     = '0;
                assign w_in_range[k] = 1'b0;
            end
        end
    endgenerate

    state_t               r_state;
    logic [W-1:0]         r_out;
    logic [SEL_W-1:0]     r_out_ch;
    logic                 r_valid;
    logic                 r_wrap;
    logic [SEL_W-1:0]     r_cur_ch;
    logic [DWELL_W-1:0]   r_cnt;
    logic [DWELL_W-1:0]   r_dwell_lat;

    state_t               w_state_d;
    logic [W-1:0]         w_out_d;
    logic [SEL_W-1:0]     w_out_ch_d;
    logic                 w_valid_d;
    logic                 w_wrap_d;
    logic [SEL_W-1:0]     w_cur_ch_d;
    logic [DWELL_W-1:0]   w_cnt_d;
    logic [DWELL_W-1:0]   w_dwell_lat_d;
    logic [SEL_W-1:0]     w_eff_ch;
    logic [DWELL_W-1:0]   w_eff_cnt;
    logic [DWELL_W-1:0]   w_eff_dl;

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_out       <= '0;
            r_out_ch    <= '0;
            r_valid     <= 1'b0;
            r_wrap      <= 1'b0;
            r_cur_ch    <= '0;
            r_cnt       <= '0;
            r_dwell_lat <= '0;
        end else begin
            r_state     <= w_state_d;
            r_out       <= w_out_d;
            r_out_ch    <= w_out_ch_d;
            r_valid     <= w_valid_d;
            r_wrap      <= w_wrap_d;
            r_cur_ch    <= w_cur_ch_d;
            r_cnt       <= w_cnt_d;
            r_dwell_lat <= w_dwell_lat_d;
        end
    end

    // Next state and next outputs. The state chosen for this edge decides
    // what the edge registers, so a mode change takes effect immediately.
    always_comb begin
        w_state_d     = c_st_idle;
        w_out_d       = r_out;
        w_out_ch_d    = r_out_ch;
        w_valid_d     = 1'b0;
        w_wrap_d      = 1'b0;
        w_cur_ch_d    = '0;
        w_cnt_d       = '0;
        w_dwell_lat_d = r_dwell_lat;
        w_eff_ch      = '0;
        w_eff_cnt     = '0;
        w_eff_dl      = '0;

        if (!en) begin
            w_state_d = c_st_idle;
        end else if (!mode) begin
            w_state_d = c_st_manual;
        end else begin
            w_state_d = c_st_scan;
        end

        case (w_state_d)
            c_st_manual: begin
                w_out_d    = w_chan[sel];
                w_out_ch_d = sel;
                w_valid_d  = w_in_range[sel];
            end
            c_st_scan: begin
                // On sweep entry the position restarts at channel 0 and the
                // dwell is captured; this same edge is the first ch0 sample.
                if (r_state == c_st_scan) begin
                    w_eff_ch  = r_cur_ch;
                    w_eff_cnt = r_cnt;
                    w_eff_dl  = r_dwell_lat;
                end else begin
                    w_eff_ch  = '0;
                    w_eff_cnt = '0;
                    w_eff_dl  = dwell;
                end

                w_out_d    = w_chan[w_eff_ch];
                w_out_ch_d = w_eff_ch;
                w_valid_d  = 1'b1;

                if (w_eff_cnt == w_eff_dl) begin
                    // Channel boundary: advance, wrapping at N_CH, and pick
                    // up the current dwell for the next channel.
                    w_cnt_d       = '0;
                    w_cur_ch_d    = (w_eff_ch == c_last_ch) ? '0 : (w_eff_ch + c_ch_one);
                    w_dwell_lat_d = dwell;
                    w_wrap_d      = (w_eff_ch == c_last_ch);
                end else begin
                    w_cnt_d       = w_eff_cnt + c_cnt_one;
                    w_cur_ch_d    = w_eff_ch;
                    w_dwell_lat_d = w_eff_dl;
                end
            end
            default: begin
                // Idle: outputs invalid, data and channel index held.
            end
        endcase
    end

    assign out       = r_out;
    assign out_ch    = r_out_ch;
    assign out_valid = r_valid;
    assign wrap      = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_mux
// Description : Self-checking bench for scan_mux. Two instances share the
//               control inputs: a 16 x 1-bit mux and a 12 x 8-bit mux.
//               A sweep-position model predicts every cycle; directed
//               literal expectations pin the model at key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_mux;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        en;
    logic        mode;
    logic [3:0]  sel;
    logic [7:0]  dwell;
    logic [15:0] in16;
    logic [95:0] in12;

    logic        out16;
    logic [3:0]  out_ch16;
    logic        valid16;
    logic        wrap16;
    logic [7:0]  out12;
    logic [3:0]  out_ch12;
    logic        valid12;
    logic        wrap12;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    scan_mux #(.N_CH(16), .W(1), .SEL_W(4), .DWELL_W(8)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .dwell(dwell),
        .in(in16), .out(out16), .out_ch(out_ch16), .out_valid(valid16), .wrap(wrap16)
    );

    scan_mux #(.N_CH(12), .W(8), .SEL_W(4), .DWELL_W(8)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .dwell(dwell),
        .in(in12), .out(out12), .out_ch(out_ch12), .out_valid(valid12), .wrap(wrap12)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: the sweep is a channel number plus the cycles still owed to it.
    // index 0 = 16-channel instance, index 1 = 12-channel instance
    // ------------------------------------------------------------------
    int         m_act [2] = '{0, 0};
    int         m_ch  [2] = '{0, 0};
    int         m_rem [2] = '{0, 0};
    logic [7:0] e_out [2] = '{8'h0, 8'h0};
    logic [3:0] e_ch  [2] = '{4'h0, 4'h0};
    logic       e_val [2] = '{1'b0, 1'b0};
    logic       e_wrp [2] = '{1'b0, 1'b0};

    function automatic int nch(input int d);
        return (d == 0) ? 16 : 12;
    endfunction

    function automatic logic [7:0] chan(input int d, input int c);
        if (c >= nch(d)) return 8'h00;
        if (d == 0) return {7'b0, in16[c]};
        return in12[c*8 +: 8];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_act[d] = 0;
                e_out[d] = 8'h0;
                e_ch[d]  = 4'h0;
                e_val[d] = 1'b0;
                e_wrp[d] = 1'b0;
            end else if (!en) begin
                m_act[d] = 0;
                e_val[d] = 1'b0;
                e_wrp[d] = 1'b0;
            end else if (!mode) begin
                m_act[d] = 0;
                e_wrp[d] = 1'b0;
                e_ch[d]  = sel;
                e_val[d] = (int'(sel) < nch(d));
                e_out[d] = chan(d, int'(sel));
            end else begin
                if (m_act[d] == 0) begin
                    m_act[d] = 1;
                    m_ch[d]  = 0;
                    m_rem[d] = int'(dwell) + 1;
                end
                e_out[d] = chan(d, m_ch[d]);
                e_ch[d]  = 4'(m_ch[d]);
                e_val[d] = 1'b1;
                e_wrp[d] = 1'b0;
                m_rem[d] = m_rem[d] - 1;
                if (m_rem[d] == 0) begin
                    e_wrp[d] = (m_ch[d] == nch(d) - 1);
                    m_ch[d]  = (m_ch[d] + 1) % nch(d);
                    m_rem[d] = int'(dwell) + 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("m16_out",   32'(out16),    32'(e_out[0]));
        check("m16_ch",    32'(out_ch16), 32'(e_ch[0]));
        check("m16_valid", 32'(valid16),  32'(e_val[0]));
        check("m16_wrap",  32'(wrap16),   32'(e_wrp[0]));
        check("m12_out",   32'(out12),    32'(e_out[1]));
        check("m12_ch",    32'(out_ch12), 32'(e_ch[1]));
        check("m12_valid", 32'(valid12),  32'(e_val[1]));
        check("m12_wrap",  32'(wrap12),   32'(e_wrp[1]));
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_out16"},   32'(out16),    32'h0);
        check({nm, "_ch16"},    32'(out_ch16), 32'h0);
        check({nm, "_valid16"}, 32'(valid16),  32'h0);
        check({nm, "_wrap16"},  32'(wrap16),   32'h0);
        check({nm, "_out12"},   32'(out12),    32'h0);
        check({nm, "_ch12"},    32'(out_ch12), 32'h0);
        check({nm, "_valid12"}, 32'(valid12),  32'h0);
        check({nm, "_wrap12"},  32'(wrap12),   32'h0);
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    logic [3:0]  man_sel [5] = '{4'h3, 4'ha, 4'h6, 4'hc, 4'hd};
    logic        man_e16 [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0]  man_e12 [5] = '{8'h13, 8'h1a, 8'h16, 8'h00, 8'h00};
    logic        man_v12 [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] scan_e16 = 16'b0011_0011_1111_1111;

    initial begin
        en    = 1'b0;
        mode  = 1'b0;
        sel   = 4'h0;
        dwell = 8'd0;
        in16  = 16'h33ff;
        for (int c = 0; c < 12; c++) in12[c*8 +: 8] = 8'h10 + 8'(c);

        #1 rst_n = 1'b0;
        step();
        step();
        check_all_zero("reset");
        rst_n = 1'b1;

        // Manual selection, including out-of-range selects on the 12-ch mux.
        en   = 1'b1;
        mode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sel = man_sel[i];
            step();
            check("man_out16",   32'(out16),    32'(man_e16[i]));
            check("man_ch16",    32'(out_ch16), 32'(man_sel[i]));
            check("man_valid16", 32'(valid16),  32'h1);
            check("man_wrap16",  32'(wrap16),   32'h0);
            check("man_out12",   32'(out12),    32'(man_e12[i]));
            check("man_valid12", 32'(valid12),  32'(man_v12[i]));
        end

        // Scan with dwell 0: one cycle per channel on both instances.
        mode  = 1'b1;
        dwell = 8'd0;
        for (int i = 0; i < 16; i++) begin
            step();
            check("scan0_out16",  32'(out16),    32'(scan_e16[i]));
            check("scan0_ch16",   32'(out_ch16), 32'(i));
            check("scan0_wrap16", 32'(wrap16),   32'(i == 15));
            check("scan0_out12",  32'(out12),    32'(8'h10 + 8'(i % 12)));
            check("scan0_wrap12", 32'(wrap12),   32'(i == 11));
        end
        step();
        check("scan0_ret_ch16", 32'(out_ch16), 32'h0);

        // Restart with dwell 2: three cycles per channel, 48-cycle sweep.
        // Input data changes mid-dwell must show up on the next sample.
        en = 1'b0;
        step();
        check("dis_valid16", 32'(valid16), 32'h0);
        en    = 1'b1;
        dwell = 8'd2;
        for (int i = 0; i < 48; i++) begin
            step();
            check("scan2_ch16",   32'(out_ch16), 32'(i / 3));
            check("scan2_wrap16", 32'(wrap16),   32'(i == 47));
            if (i == 7)  in16 = 16'hcc00;
            if (i == 20) in16 = 16'h33ff;
        end
        for (int i = 0; i < 16; i++) begin
            step();
            check("scan2b_ch16", 32'(out_ch16), 32'(i / 3));
        end
        // Now on the first cycle of ch5: shorten the dwell mid-channel.
        dwell = 8'd0;
        step();
        check("dchg_ch5a", 32'(out_ch16), 32'h5);
        step();
        check("dchg_ch5b", 32'(out_ch16), 32'h5);
        for (int c = 6; c < 16; c++) begin
            step();
            check("dchg_ch16",   32'(out_ch16), 32'(c));
            check("dchg_wrap16", 32'(wrap16),   32'(c == 15));
        end
        step();
        check("dchg_ret_ch16", 32'(out_ch16), 32'h0);

        // Asynchronous reset mid-scan at ch7.
        en = 1'b0;
        step();
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("pre_rst_ch16", 32'(out_ch16), 32'(i));
        end
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_ch16",    32'(out_ch16), 32'h0);
        check("post_rst_valid16", 32'(valid16),  32'h1);

        // Enable toggle at ch9: outputs hold while disabled, sweep restarts.
        for (int i = 1; i < 10; i++) begin
            step();
            check("pre_dis_ch16", 32'(out_ch16), 32'(i));
        end
        en   = 1'b0;
        in16 = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            step();
            check("hold_valid16", 32'(valid16),  32'h0);
            check("hold_out16",   32'(out16),    32'h1);
            check("hold_ch16",    32'(out_ch16), 32'h9);
            check("hold_out12",   32'(out12),    32'h19);
        end
        en = 1'b1;
        step();
        check("reen_ch16",    32'(out_ch16), 32'h0);
        check("reen_valid16", 32'(valid16),  32'h1);
        check("reen_out16",   32'(out16),    32'h0);
        in16 = 16'h33ff;
        step();
        check("reen_ch16b",   32'(out_ch16), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
